// File: rtl/rr_sel_arbiter4.sv
// Round-robin 4-channel scheduler driving the 2-bit select of a 4:1 bus mux.
// Grants are burst-limited to MAX_BURST cycles; sel/gnt/sel_valid are registered.
module rr_sel_arbiter4 #(
    parameter  int MAX_BURST = 4,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic [3:0] gnt,
    output logic       burst_last
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [1:0]       last;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       nxt;
    logic             at_limit;
    logic             rel;
    logic             any_req;

    // Scan p+1, p+2, p+3, then p itself; the nearest requester overrides.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        pick = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    // last equals sel while granted, so one pointer serves both states
    assign nxt        = pick(req, last);
    assign any_req    = |req;
    assign at_limit   = (cnt == CNT_W'(MAX_BURST));
    assign rel        = !req[sel] || at_limit;
    assign burst_last = sel_valid && at_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 2'd0;
            sel_valid <= 1'b0;
            gnt       <= 4'b0000;
            cnt       <= '0;
            last      <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= GRANT;
                        sel       <= nxt;
                        sel_valid <= 1'b1;
                        gnt       <= 4'b0001 << nxt;
                        cnt       <= CNT_W'(1);
                        last      <= nxt;
                    end
                end
                GRANT: begin
                    if (!rel) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (any_req) begin
                        sel  <= nxt;
                        gnt  <= 4'b0001 << nxt;
                        cnt  <= CNT_W'(1);
                        last <= nxt;
                    end else begin
                        // sel holds so the mux input stays stable while idle
                        state     <= IDLE;
                        sel_valid <= 1'b0;
                        gnt       <= 4'b0000;
                        cnt       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Self-checking bench for rr_sel_arbiter4: table-driven vectors through a
// scoreboard queue, plus hand-written async-reset sequences.
module tb_rr_sel_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [1:0] sel;
    logic       sel_valid;
    logic [3:0] gnt;
    logic       burst_last;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic       sv;
        logic [3:0] gnt;
        logic       bl;
    } out_t;

    typedef struct {
        logic [3:0] req;
        out_t       exp;
        string      tag;
    } vec_t;

    vec_t vecs[$];
    out_t exp_q[$];

    rr_sel_arbiter4 #(.MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .sel(sel), .sel_valid(sel_valid), .gnt(gnt), .burst_last(burst_last)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic [1:0] s, input logic v, input logic b);
        mk.sel = s;
        mk.sv  = v;
        mk.gnt = v ? (4'b0001 << s) : 4'b0000;
        mk.bl  = b;
    endfunction

    function automatic void add(input logic [3:0] r, input out_t e, input string t);
        vec_t x;
        x.req = r; x.exp = e; x.tag = t;
        vecs.push_back(x);
    endfunction

    task automatic compare(input string t, input out_t e);
        out_t a;
        a = '{sel: sel, sv: sel_valid, gnt: gnt, bl: burst_last};
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got sel=%0d sv=%0b gnt=%b bl=%0b, want sel=%0d sv=%0b gnt=%b bl=%0b",
                     t, a.sel, a.sv, a.gnt, a.bl, e.sel, e.sv, e.gnt, e.bl);
        end
    endtask

    // Drive at negedge, push expectation, pop and compare 1 unit after posedge.
    task automatic run_vecs();
        out_t e;
        foreach (vecs[i]) begin
            @(negedge clk);
            req = vecs[i].req;
            exp_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            compare(vecs[i].tag, e);
        end
        vecs.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1 compare("reset_clear", mk(2'd0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Async reset with all requests high and no clock edge yet
        #1;
        req   = 4'hF;
        rst_n = 1'b0;
        #1 compare("async_reset", mk(2'd0, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        compare("reset_hold", mk(2'd0, 1'b0, 1'b0));
        req   = 4'h0;
        rst_n = 1'b1;

        // Sole requester ch0: burst limit at cycles 4 and 8, re-granted without a gap
        for (int k = 1; k <= 10; k++)
            add(4'b0001, mk(2'd0, 1'b1, (k == 4) || (k == 8)), $sformatf("solo_c%0d", k));
        add(4'b0000, mk(2'd0, 1'b0, 1'b0), "solo_idle");
        run_vecs();

        // All requesting: 0,1,2,3,0 each for 4 cycles
        do_reset();
        for (int k = 0; k < 20; k++)
            add(4'b1111, mk(2'((k / 4) % 4), 1'b1, (k % 4) == 3), $sformatf("all_c%0d", k));
        add(4'b0000, mk(2'd0, 1'b0, 1'b0), "all_idle");
        run_vecs();

        // ch0 drops after 2 granted cycles -> ch2 in one cycle
        do_reset();
        add(4'b0101, mk(2'd0, 1'b1, 1'b0), "drop_c1");
        add(4'b0101, mk(2'd0, 1'b1, 1'b0), "drop_c2");
        add(4'b0100, mk(2'd2, 1'b1, 1'b0), "drop_handoff");
        add(4'b0100, mk(2'd2, 1'b1, 1'b0), "drop_c4");
        add(4'b0000, mk(2'd2, 1'b0, 1'b0), "drop_idle");
        // ch3 for 2 cycles, idle with sel held at 3, then 1001 rotates to ch0
        add(4'b1000, mk(2'd3, 1'b1, 1'b0), "ch3_c1");
        add(4'b1000, mk(2'd3, 1'b1, 1'b0), "ch3_c2");
        add(4'b0000, mk(2'd3, 1'b0, 1'b0), "ch3_idle1");
        add(4'b0000, mk(2'd3, 1'b0, 1'b0), "ch3_idle2");
        add(4'b1001, mk(2'd0, 1'b1, 1'b0), "rot_from3");
        // ch0 leaves, ch2 takes over; a ch1 request mid-burst must not preempt
        add(4'b0100, mk(2'd2, 1'b1, 1'b0), "to_ch2");
        add(4'b0110, mk(2'd2, 1'b1, 1'b0), "no_preempt");
        run_vecs();

        // Reset mid-burst on ch2: outputs clear without an edge, restart from pointer 3
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 compare("midburst_async", mk(2'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1 compare("midburst_hold", mk(2'd0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        add(4'b0110, mk(2'd1, 1'b1, 1'b0), "post_reset_ch1");
        add(4'b0110, mk(2'd1, 1'b1, 1'b0), "post_reset_c2");
        run_vecs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Structural invariant: gnt is one-hot or zero and matches sel/sel_valid
    always @(negedge clk) begin
        if (rst_n) begin
            n_chk++;
            if (gnt !== (sel_valid ? (4'b0001 << sel) : 4'b0000)) begin
                n_fail++;
                $display("FAIL gnt_track: got gnt=%b, want %b (sel=%0d sv=%0b)",
                         gnt, sel_valid ? (4'b0001 << sel) : 4'b0000, sel, sel_valid);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish by t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
